// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86 memory port arbiter: FSM states,
// requester ownership and the pipeline status codes derived from access errors.
package y86_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE,
        ERR
    } state_e;

    typedef enum logic {
        OWN_F,
        OWN_D
    } owner_e;

    localparam int BYTES_PER_WORD = 8;

    localparam logic [1:0] STAT_AOK = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd3;

    // The stat stage reports an address fault whenever an access ended with err.
    function automatic logic [1:0] err_to_stat(input logic err);
        return err ? STAT_ADR : STAT_AOK;
    endfunction

endpackage

// File: rtl/y86_word_serdes.sv
// Byte serialiser for one 64-bit little-endian word: a 3-bit lane counter, the
// write-byte mux and the read-assembly register that collects returning bytes.
module y86_word_serdes
    import y86_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  rbyte_i,
    output logic [2:0]  count_o,
    output logic        last_o,
    output logic [7:0]  wbyte_o,
    output logic [63:0] word_o
);

    logic [2:0]  count_q;
    logic [63:0] stage_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            stage_q <= '0;
        end else if (load_i) begin
            count_q <= '0;
        end else if (step_i) begin
            count_q                         <= count_q + 3'd1;
            stage_q[{count_q, 3'b000} +: 8] <= rbyte_i;
        end
    end

    // Lane being transferred this cycle is taken live from the RAM so the
    // final byte can be delivered at the same edge that captures it.
    always_comb begin
        // NOTE: full default before the partial overwrite keeps this combinational
        // and prevents a latch on word_o.
        word_o                         = stage_q;
        word_o[{count_q, 3'b000} +: 8] = rbyte_i;
    end

    assign count_o = count_q;
    assign last_o  = (count_q == 3'(BYTES_PER_WORD - 1));
    assign wbyte_o = wdata_i[{count_q, 3'b000} +: 8];

endmodule

// File: rtl/y86_mem_port_arbiter.sv
// Arbitrates the fetch and memory stages onto one byte-wide RAM, serialising
// each 8-byte access, flagging out-of-range bases and pulsing done per owner.
module y86_mem_port_arbiter
    import y86_mem_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [63:0]       f_addr,
    output logic              f_done,
    output logic              f_err,
    output logic [63:0]       f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [63:0]       d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_done,
    output logic              d_err,
    output logic [63:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    localparam logic [63:0] MAX_BASE = 64'(MEM_BYTES - BYTES_PER_WORD);

    state_e            state_q;
    owner_e            owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [63:0]       wdata_q;
    logic              f_done_q, f_err_q, d_done_q, d_err_q;
    logic [63:0]       f_rdata_q, d_rdata_q;

    logic [63:0] grant_addr;
    logic        grant_legal;
    logic [2:0]  count;
    logic        last;
    logic [7:0]  wbyte;
    logic [63:0] word;

    // Full 64-bit compare: a huge address must never alias into the RAM.
    assign grant_addr  = d_req ? d_addr : f_addr;
    assign grant_legal = (grant_addr <= MAX_BASE);

    y86_word_serdes u_serdes (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (state_q == IDLE),
        .step_i  (state_q == XFER),
        .wdata_i (wdata_q),
        .rbyte_i (mem_rdata),
        .count_o (count),
        .last_o  (last),
        .wbyte_o (wbyte),
        .word_o  (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_F;
            we_q      <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
            f_done_q  <= 1'b0;
            f_err_q   <= 1'b0;
            d_done_q  <= 1'b0;
            d_err_q   <= 1'b0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            f_done_q <= 1'b0;
            f_err_q  <= 1'b0;
            d_done_q <= 1'b0;
            d_err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (d_req || f_req) begin
                        owner_q <= d_req ? OWN_D : OWN_F;
                        we_q    <= d_req && d_we;
                        base_q  <= grant_addr[ADDR_W-1:0];
                        wdata_q <= d_wdata;
                        if (grant_legal) begin
                            state_q <= XFER;
                        end else begin
                            state_q <= ERR;
                            if (d_req) begin
                                d_done_q  <= 1'b1;
                                d_err_q   <= 1'b1;
                                d_rdata_q <= '0;
                            end else begin
                                f_done_q  <= 1'b1;
                                f_err_q   <= 1'b1;
                                f_rdata_q <= '0;
                            end
                        end
                    end
                end
                XFER: begin
                    if (last) begin
                        state_q <= DONE;
                        if (owner_q == OWN_D) begin
                            d_done_q <= 1'b1;
                            if (!we_q) d_rdata_q <= word;
                        end else begin
                            f_done_q <= 1'b1;
                            if (!we_q) f_rdata_q <= word;
                        end
                    end
                end
                DONE, ERR: state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr  = (state_q == XFER) ? base_q + ADDR_W'(count) : '0;
    assign mem_we    = (state_q == XFER) && we_q;
    assign mem_wdata = mem_we ? wbyte : 8'h00;
    assign busy      = (state_q != IDLE);
    assign f_done    = f_done_q;
    assign f_err     = f_err_q;
    assign f_rdata   = f_rdata_q;
    assign d_done    = d_done_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

endmodule
